mem_port_arbiter: RTL

Shares a single-ported unified memory between the instruction-fetch requester (IF stage) and the load/store requester (LSU in the MEM stage) of the 5-stage pipelined core. It serialises requests, sequences the memory access over a fixed wait-state count and returns read data or a write acknowledge to the granted requester. Un-granted requesters see their grant low and must stall their stage.

---
 rtl/mem_port_arbiter_if.sv | 32 +++
 rtl/mem_port_arbiter.sv | 68 ++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IF/LSU requester and memory-side signals of the shared memory port.
interface mem_port_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i;
  logic        ls_we_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic [3:0]  ls_be_i;
  logic        ls_gnt_o;
  logic        ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;
  modport slave (
    input  if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );
  modport master (
    output if_req_i, if_addr_i, ls_req_i, ls_we_i, ls_addr_i, ls_wdata_i, ls_be_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, ls_gnt_o, ls_rvalid_o, ls_rdata_o,
           mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises IF and LSU accesses onto one single-ported memory, LSU first.
// Optional IF starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int STARVE_MAX  = 4
) (
  input logic clk_i,
  input logic rst_ni,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t      state;
  logic        owner_ls, we_r;
  logic [31:0] addr_r, wdata_r, cap_r;
  logic [3:0]  be_r, cnt;
  logic        busy, resp, window, ls_win, gnt;
  assign busy   = state == BUSY;
  assign resp   = state == RESP;
  // gating with rst_ni keeps the combinational grants at 0 while reset is held
  assign window = rst_ni && !busy;
`ifdef ARB_STARVE_GUARD_EN
  logic [3:0] starve;
  assign ls_win = bus.ls_req_i && !(bus.if_req_i && starve == 4'(STARVE_MAX));
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) starve <= '0;
    else if (bus.ls_gnt_o) starve <= bus.if_req_i ? starve + 4'd1 : 4'd0;
    else if (bus.if_gnt_o) starve <= '0;
`else
  assign ls_win = bus.ls_req_i;
`endif
  assign bus.ls_gnt_o    = window && ls_win;
  assign bus.if_gnt_o    = window && bus.if_req_i && !ls_win;
  assign gnt             = bus.ls_gnt_o || bus.if_gnt_o;
  assign bus.mem_req_o   = busy;
  assign bus.mem_we_o    = busy && we_r;
  assign bus.mem_addr_o  = busy ? addr_r : '0;
  assign bus.mem_wdata_o = busy ? wdata_r : '0;
  assign bus.mem_be_o    = busy ? be_r : '0;
  assign bus.ls_rvalid_o = resp && owner_ls;
  assign bus.if_rvalid_o = resp && !owner_ls;
  assign bus.ls_rdata_o  = bus.ls_rvalid_o ? cap_r : '0;
  assign bus.if_rdata_o  = bus.if_rvalid_o ? cap_r : '0;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state    <= IDLE;
      owner_ls <= 1'b0;
      we_r     <= 1'b0;
      addr_r   <= '0;
      wdata_r  <= '0;
      be_r     <= '0;
      cnt      <= '0;
      cap_r    <= '0;
    end else if (gnt) begin
      state    <= BUSY;
      owner_ls <= bus.ls_gnt_o;
      we_r     <= bus.ls_gnt_o && bus.ls_we_i;
      addr_r   <= bus.ls_gnt_o ? bus.ls_addr_i : bus.if_addr_i;
      wdata_r  <= bus.ls_gnt_o ? bus.ls_wdata_i : '0;
      be_r     <= bus.ls_gnt_o ? bus.ls_be_i : 4'hF;
      cnt      <= 4'(WAIT_CYCLES - 1);
    end else if (busy) begin
      state <= cnt == '0 ? RESP : BUSY;
      cnt   <= cnt == '0 ? cnt : cnt - 4'd1;
      cap_r <= cnt == '0 ? (we_r ? '0 : bus.mem_rdata_i) : cap_r;
    end else
      state <= IDLE;
  assert property (@(posedge clk_i) WAIT_CYCLES inside {[1:15]} && STARVE_MAX inside {[1:15]});
endmodule
